bus_arbiter_xbar: RTL and testbench
===================================

// Module: bus_arbiter_xbar
// PURPOSE
//   Parametrised shared-bus interconnect, successor to the fixed 1-master/5-slave bus. Connects NM masters
//   (core LSU, JTAG mem port, future DMA) to NS slaves (rom, ram, timer, uart, gpio, ...) with round-robin
//   arbitration and address-field decode. Carries one transaction at a time.
//   Adds decode-error and timeout-error responses so a hung or absent slave cannot stall a master.
// PARAMETERS
//   NM        2    number of masters, 1..8
//   NS        5    number of slaves, 1..16
//   SEL_LSB   28   slave index = addr[SEL_LSB+3:SEL_LSB] (4-bit field, 256 MB per slave)
//   TMO_CYC   255  ACCESS cycles allowed before timeout error, 1..65535
// PORTS
//   clk_i       in   1      system clock, all logic on rising edge
//   rst_i       in   1      asynchronous, active-high reset
//   m_req_i     in   NM     per-master request; held until m_gnt_o
//   m_sel_i     in   4*NM   byte enables, master k at [4k+3:4k]
//   m_addr_i    in   32*NM  address, master k at [32k+31:32k]
//   m_we_i      in   NM     1=write, 0=read
//   m_data_i    in   32*NM  write data
//   m_gnt_o     out  NM     one-cycle pulse: request accepted, master may drop/change request
//   m_rvalid_o  out  NM     one-cycle pulse: read data / write ack / error for that master
//   m_err_o     out  1      qualifies m_rvalid_o: 1 = decode or timeout error
//   m_data_o    out  32     read data, valid with m_rvalid_o
//   s_req_o     out  NS     one-hot slave chip-enable, held for whole ACCESS
//   s_sel_o     out  4      latched byte enables
//   s_addr_o    out  32     latched address
//   s_we_o      out  1      latched write enable
//   s_data_o    out  32     latched write data
//   s_rvalid_i  in   NS     slave response (read data valid or write ack)
//   s_data_i    in   32*NS  slave read data, slave j at [32j+31:32j]
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr pointer=0 (master 0 highest priority); timeout counter 0.
//   States: IDLE, ACCESS, RESP.
//   IDLE: if any m_req_i, pick first requester at/after rr pointer (wrapping modulo NM). Next edge:
//     m_gnt_o[w]=1 for one cycle; latch sel/addr/we/data and owner w; rr pointer <= (w+1) mod NM.
//     idx = addr field; idx < NS -> ACCESS with s_req_o[idx]=1; idx >= NS -> RESP with error, no s_req_o.
//   ACCESS: s_req_o/s_* held stable. Counter increments each cycle.
//     s_rvalid_i[idx]=1 -> capture s_data_i slice idx, err=0, go RESP, s_req_o<=0.
//     counter reaches TMO_CYC with no rvalid -> err=1, data=0, go RESP. rvalid on that same cycle wins (no error).
//     s_rvalid_i from non-selected slaves ignored at all times.
//   RESP: m_rvalid_o[owner]=1, m_err_o, m_data_o valid for exactly one cycle; then IDLE, counter=0.
//     Write responses return m_data_o=0. Error response: m_data_o=0, m_err_o=1.
//   Latency (zero-wait slave answering in first ACCESS cycle): req@0 -> gnt@1 -> rvalid@3. Back-to-back: next grant
//     earliest the cycle after RESP (no overlap; throughput 1 txn / 3 cycles min).
//   m_data_o/m_err_o are 0 whenever m_rvalid_o is all zero.
//   Master dropping m_req_i after gnt does not abort; response still delivered to owner.
//   Master holding m_req_i high after gnt issues a new request arbitrated in next IDLE.
//   Async reset mid-ACCESS: s_req_o drops immediately, in-flight transaction discarded, no m_rvalid_o issued.
//   NM=1: arbiter degenerates to pass-through, rr pointer stays 0.
// TESTING
//   1 NM=2,NS=5: M0 read 0x1000_0010, ram rvalid after 2 cycles with 0xCAFE0001 -> s_req_o=5'b00010, M0 rvalid, data 0xCAFE0001, err=0.
//   2 M0 and M1 request same cycle, both repeatedly -> grants alternate M0,M1,M0,M1; never two grants in one cycle.
//   3 M1 write 0x7000_0000 (idx 7 >= NS) -> no s_req_o, m_gnt_o[1] then m_rvalid_o[1] with err=1, data=0.
//   4 TMO_CYC=4, uart never responds -> s_req_o[3] held 4 cycles, then m_rvalid_o err=1; rvalid on cycle 4 -> err=0.
//   5 rst_i pulsed during ACCESS -> all outputs 0 same cycle; after release M0 wins first even if M1 last granted.
//   6 spurious s_rvalid_i[2] while accessing slave 1 -> ignored, transaction completes on s_rvalid_i[1] only.

Source files
------------

// File: rtl/bus_arbiter_xbar_if.sv
// Bus bundle between the masters, the interconnect and the slaves.
// The slave modport is the interconnect's view; master is the surrounding system's view.
interface bus_arbiter_xbar_if #(
    parameter int NM = 2,
    parameter int NS = 5
);
    logic [NM-1:0]      m_req_i;
    logic [4*NM-1:0]    m_sel_i;
    logic [32*NM-1:0]   m_addr_i;
    logic [NM-1:0]      m_we_i;
    logic [32*NM-1:0]   m_data_i;
    logic [NM-1:0]      m_gnt_o;
    logic [NM-1:0]      m_rvalid_o;
    logic               m_err_o;
    logic [31:0]        m_data_o;
    logic [NS-1:0]      s_req_o;
    logic [3:0]         s_sel_o;
    logic [31:0]        s_addr_o;
    logic               s_we_o;
    logic [31:0]        s_data_o;
    logic [NS-1:0]      s_rvalid_i;
    logic [32*NS-1:0]   s_data_i;

    modport slave (
        input  m_req_i, m_sel_i, m_addr_i, m_we_i, m_data_i, s_rvalid_i, s_data_i,
        output m_gnt_o, m_rvalid_o, m_err_o, m_data_o,
               s_req_o, s_sel_o, s_addr_o, s_we_o, s_data_o
    );

    modport master (
        output m_req_i, m_sel_i, m_addr_i, m_we_i, m_data_i, s_rvalid_i, s_data_i,
        input  m_gnt_o, m_rvalid_o, m_err_o, m_data_o,
               s_req_o, s_sel_o, s_addr_o, s_we_o, s_data_o
    );
endinterface

// File: rtl/bus_arbiter_xbar.sv
// Single-transaction shared-bus interconnect: round-robin master arbitration, address-field
// slave decode, and decode/timeout error responses so an absent or hung slave cannot stall a master.
module bus_arbiter_xbar #(
    parameter int NM      = 2,
    parameter int NS      = 5,
    parameter int SEL_LSB = 28,
    parameter int TMO_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bus_arbiter_xbar_if.slave bus
);
    localparam int PW = (NM > 1) ? $clog2(NM) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    logic [1:0]    state_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] owner_r;
    logic [15:0]   cnt_r;
    logic          err_r;
    logic [31:0]   rdata_r;

    logic [NS-1:0] s_req_r;
    logic [3:0]    s_sel_r;
    logic [31:0]   s_addr_r;
    logic          s_we_r;
    logic [31:0]   s_data_r;
    logic [NM-1:0] m_gnt_r;
    logic [NM-1:0] m_rvalid_r;
    logic          m_err_r;
    logic [31:0]   m_data_r;

    logic          found_s;
    logic [PW-1:0] win_s;
    logic [PW-1:0] ptr_nxt_s;
    int            best_s;
    int            dist_s;
    logic          take_s;
    logic [NM-1:0] win_hot_s;
    logic [NM-1:0] own_hot_s;
    logic [3:0]    sel_s;
    logic [31:0]   addr_s;
    logic          we_s;
    logic [31:0]   data_s;
    logic [3:0]    idx_s;
    logic          in_range_s;
    logic [NS-1:0] dec_s;
    logic          slv_hit_s;
    logic [31:0]   slv_data_s;

    // Round-robin pick: requester with the smallest distance from the pointer wins.
    always_comb begin
        best_s = NM;
        dist_s = 0;
        take_s = 1'b0;
        win_s  = '0;
        for (int k = 0; k < NM; k++) begin
            dist_s = (k + NM - int'(ptr_r)) % NM;
            take_s = bus.m_req_i[k] && (dist_s < best_s);
            best_s = take_s ? dist_s : best_s;
            win_s  = take_s ? PW'(k) : win_s;
        end
        found_s   = (best_s < NM);
        ptr_nxt_s = PW'((int'(win_s) + 1) % NM);
    end

    // Winner's request fields, owner one-hot, and slave decode of the winner's address.
    always_comb begin
        sel_s  = 4'd0;
        addr_s = 32'd0;
        we_s   = 1'b0;
        data_s = 32'd0;
        for (int k = 0; k < NM; k++) begin
            win_hot_s[k] = (win_s == PW'(k));
            own_hot_s[k] = (owner_r == PW'(k));
            sel_s  = win_hot_s[k] ? bus.m_sel_i[4*k +: 4]   : sel_s;
            addr_s = win_hot_s[k] ? bus.m_addr_i[32*k +: 32] : addr_s;
            we_s   = win_hot_s[k] ? bus.m_we_i[k]            : we_s;
            data_s = win_hot_s[k] ? bus.m_data_i[32*k +: 32] : data_s;
        end
        idx_s      = addr_s[SEL_LSB +: 4];
        in_range_s = ({1'b0, idx_s} < 5'(NS));
        for (int j = 0; j < NS; j++) begin
            dec_s[j] = in_range_s && (idx_s == 4'(j));
        end
    end

    // Only the slave currently enabled can complete the access; others are masked out.
    always_comb begin
        slv_hit_s  = 1'b0;
        slv_data_s = 32'd0;
        for (int j = 0; j < NS; j++) begin
            slv_hit_s  = slv_hit_s | (s_req_r[j] & bus.s_rvalid_i[j]);
            slv_data_s = slv_data_s | ({32{s_req_r[j]}} & bus.s_data_i[32*j +: 32]);
        end
    end

    // Transaction FSM; every output is a register so reset clears them immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            owner_r    <= '0;
            cnt_r      <= 16'd0;
            err_r      <= 1'b0;
            rdata_r    <= 32'd0;
            s_req_r    <= '0;
            s_sel_r    <= 4'd0;
            s_addr_r   <= 32'd0;
            s_we_r     <= 1'b0;
            s_data_r   <= 32'd0;
            m_gnt_r    <= '0;
            m_rvalid_r <= '0;
            m_err_r    <= 1'b0;
            m_data_r   <= 32'd0;
        end else begin
            m_gnt_r    <= '0;
            m_rvalid_r <= '0;
            m_err_r    <= 1'b0;
            m_data_r   <= 32'd0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        m_gnt_r  <= win_hot_s;
                        owner_r  <= win_s;
                        ptr_r    <= ptr_nxt_s;
                        s_sel_r  <= sel_s;
                        s_addr_r <= addr_s;
                        s_we_r   <= we_s;
                        s_data_r <= data_s;
                        cnt_r    <= 16'd0;
                        rdata_r  <= 32'd0;
                        if (in_range_s) begin
                            s_req_r <= dec_s;
                            err_r   <= 1'b0;
                            state_r <= ST_ACCESS;
                        end else begin
                            s_req_r <= '0;
                            err_r   <= 1'b1;
                            state_r <= ST_RESP;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // A response in the final allowed cycle beats the timeout.
                    if (slv_hit_s) begin
                        s_req_r <= '0;
                        err_r   <= 1'b0;
                        rdata_r <= s_we_r ? 32'd0 : slv_data_s;
                        state_r <= ST_RESP;
                    end else if (cnt_r == TMO_LAST) begin
                        s_req_r <= '0;
                        err_r   <= 1'b1;
                        rdata_r <= 32'd0;
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r   <= cnt_r + 16'd1;
                    end
                end
                ST_RESP: begin
                    m_rvalid_r <= own_hot_s;
                    m_err_r    <= err_r;
                    m_data_r   <= rdata_r;
                    cnt_r      <= 16'd0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    s_req_r <= '0;
                    cnt_r   <= 16'd0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_gnt_o    = m_gnt_r;
    assign bus.m_rvalid_o = m_rvalid_r;
    assign bus.m_err_o    = m_err_r;
    assign bus.m_data_o   = m_data_r;
    assign bus.s_req_o    = s_req_r;
    assign bus.s_sel_o    = s_sel_r;
    assign bus.s_addr_o   = s_addr_r;
    assign bus.s_we_o     = s_we_r;
    assign bus.s_data_o   = s_data_r;
endmodule

// File: tb/tb_bus_arbiter_xbar.sv
// Randomized bench for bus_arbiter_xbar: masters push expected responses into per-master
// queues, a negedge monitor pops and compares them; slaves answer after an address-derived delay.
module tb_bus_arbiter_xbar;
    localparam int NM      = 2;
    localparam int NS      = 5;
    localparam int SEL_LSB = 28;
    localparam int TMO     = 4;
    localparam int NTXN    = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_xbar_if #(.NM(NM), .NS(NS)) bus ();

    bus_arbiter_xbar #(.NM(NM), .NS(NS), .SEL_LSB(SEL_LSB), .TMO_CYC(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          lat;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } exp_t;

    exp_t          exp_q[NM][$];
    int            gnt_q[NM][$];
    exp_t          cur;
    exp_t          mon_e;
    int            mon_g;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            slv_acc = 0;
    logic [NM-1:0] pend = '0;
    int            age[NM];
    int            last_gnt = NM - 1;
    int            issued = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave j's response delay (ACCESS cycle it answers in) and read data, from the address alone.
    function automatic int lat_of(input logic [31:0] a);
        return (int'(a[4:2]) % 6) + 1;
    endfunction

    function automatic logic [31:0] rd_of(input int j, input logic [31:0] a);
        return 32'hCAFE_0000 ^ {a[15:0], a[31:16]} ^ (32'(j) << 24);
    endfunction

    function automatic int outstanding();
        int n = 0;
        for (int k = 0; k < NM; k++) n += exp_q[k].size() + int'(pend[k]);
        return n;
    endfunction

    task automatic issue(input int k, input logic [31:0] a, input logic we);
        exp_t e;
        int   idx;
        idx     = int'(a[31:28]);
        e.addr  = a;
        e.we    = we;
        e.wdata = $urandom;
        e.sel   = 4'($urandom_range(0, 15));
        if (idx >= NS) begin
            e.err = 1'b1; e.data = 32'd0; e.lat = 1;
        end else if (lat_of(a) > TMO) begin
            e.err = 1'b1; e.data = 32'd0; e.lat = TMO + 1;
        end else begin
            e.err = 1'b0; e.data = we ? 32'd0 : rd_of(idx, a); e.lat = lat_of(a) + 1;
        end
        exp_q[k].push_back(e);
        bus.m_req_i[k]           = 1'b1;
        bus.m_we_i[k]            = we;
        bus.m_addr_i[32*k +: 32] = a;
        bus.m_data_i[32*k +: 32] = e.wdata;
        bus.m_sel_i[4*k +: 4]    = e.sel;
        pend[k] = 1'b1;
        age[k]  = 0;
        issued++;
    endtask

    // One clock of master activity: account for grants, then optionally raise new requests.
    task automatic step(input bit allow_new);
        logic [NM-1:0] req_seen;
        logic [31:0]   a;
        int            exp_w;
        int            idx;
        @(posedge clk);
        #1;
        req_seen = bus.m_req_i;
        if (bus.m_gnt_o != '0) begin
            check("gnt_onehot", 64'($onehot(bus.m_gnt_o)), 64'd1);
            exp_w = -1;
            for (int i = 1; i <= NM; i++) begin
                idx = (last_gnt + i) % NM;
                if (exp_w < 0 && req_seen[idx]) exp_w = idx;
            end
            for (int k = 0; k < NM; k++) begin
                if (bus.m_gnt_o[k]) begin
                    check("gnt_winner", 64'(k), 64'(exp_w));
                    check("gnt_requested", 64'(pend[k]), 64'd1);
                    if (exp_q[k].size() > 0) cur = exp_q[k][exp_q[k].size() - 1];
                    gnt_q[k].push_back(cyc);
                    pend[k] = 1'b0;
                    bus.m_req_i[k] = 1'b0;
                    last_gnt = k;
                end
            end
        end
        for (int k = 0; k < NM; k++) begin
            if (pend[k]) begin
                age[k]++;
                if (age[k] > 100) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL gnt_timeout: master %0d waited %0d cycles, required grant within 100", k, age[k]);
                    pend[k] = 1'b0;
                    bus.m_req_i[k] = 1'b0;
                    void'(exp_q[k].pop_back());
                end
            end else if (allow_new && issued < NTXN && $urandom_range(0, 2) != 0) begin
                a = $urandom;
                a[31:28] = 4'($urandom_range(0, 6));
                issue(k, a, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && outstanding() != 0; c++) step(1'b0);
        check("drain_empty", 64'(outstanding()), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_m"}, 64'({bus.m_gnt_o, bus.m_rvalid_o, bus.m_err_o, bus.m_data_o}), 64'd0);
        check({name, "_s"}, 64'({bus.s_req_o, bus.s_sel_o, bus.s_we_o, bus.s_addr_o}), 64'd0);
        check({name, "_sd"}, 64'(bus.s_data_o), 64'd0);
    endtask

    // Slave models: the enabled slave answers once in its delay cycle; the rest emit noise.
    initial begin
        bus.s_rvalid_i = '0;
        bus.s_data_i   = '0;
        forever begin
            @(posedge clk);
            #1;
            slv_acc = (bus.s_req_o != '0) ? slv_acc + 1 : 0;
            for (int j = 0; j < NS; j++) begin
                if (bus.s_req_o[j] && slv_acc == lat_of(bus.s_addr_o)) begin
                    bus.s_rvalid_i[j]        = 1'b1;
                    bus.s_data_i[32*j +: 32] = rd_of(j, bus.s_addr_o);
                end else if (bus.s_req_o[j]) begin
                    bus.s_rvalid_i[j]        = 1'b0;
                    bus.s_data_i[32*j +: 32] = $urandom;
                end else begin
                    bus.s_rvalid_i[j]        = ($urandom_range(0, 3) == 0);
                    bus.s_data_i[32*j +: 32] = $urandom;
                end
            end
        end
    end

    // Response monitor and bus-side checks, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.m_rvalid_o == '0) begin
                check("idle_resp_zero", 64'({bus.m_err_o, bus.m_data_o}), 64'd0);
            end else begin
                check("rvalid_onehot", 64'($onehot(bus.m_rvalid_o)), 64'd1);
                for (int k = 0; k < NM; k++) begin
                    if (bus.m_rvalid_o[k]) begin
                        if (exp_q[k].size() == 0 || gnt_q[k].size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL rvalid_unexpected: master %0d got a response, required none outstanding", k);
                        end else begin
                            mon_e = exp_q[k].pop_front();
                            mon_g = gnt_q[k].pop_front();
                            check("resp_err", 64'(bus.m_err_o), 64'(mon_e.err));
                            check("resp_data", 64'(bus.m_data_o), 64'(mon_e.data));
                            check("resp_latency", 64'(cyc - mon_g), 64'(mon_e.lat));
                        end
                    end
                end
            end
            if (bus.s_req_o != '0) begin
                check("s_req_decode", 64'(bus.s_req_o), 64'(NS'(1) << cur.addr[31:28]));
                check("s_fields", 64'({bus.s_sel_o, bus.s_we_o, bus.s_addr_o}), 64'({cur.sel, cur.we, cur.addr}));
                check("s_wdata", 64'(bus.s_data_o), 64'(cur.wdata));
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          n;
        bus.m_req_i  = '0;
        bus.m_sel_i  = '0;
        bus.m_addr_i = '0;
        bus.m_we_i   = '0;
        bus.m_data_i = '0;
        for (int k = 0; k < NM; k++) age[k] = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;

        // Random traffic from both masters, including decode errors and timeouts.
        for (int c = 0; c < 8000 && issued < NTXN; c++) step(1'b1);
        drain();

        // Reset in the middle of an ACCESS owned by master 1 (slow ram access).
        issue(1, 32'h1000_0014, 1'b0);
        n = 0;
        while (bus.s_req_o == '0 && n < 20) begin
            step(1'b0);
            n++;
        end
        check("rst_setup_access", 64'(bus.s_req_o), 64'h2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async_clear");
        for (int k = 0; k < NM; k++) begin
            exp_q[k].delete();
            gnt_q[k].delete();
        end
        pend        = '0;
        bus.m_req_i = '0;
        last_gnt    = NM - 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Both masters request together after reset: master 0 must win first.
        issue(1, 32'h2000_0008, 1'b1);
        issue(0, 32'h1000_0004, 1'b0);
        n = 0;
        while (pend == 2'b11 && n < 20) begin
            step(1'b0);
            n++;
        end
        check("rst_first_winner", 64'(pend), 64'h2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
